// File: rtl/seqsum_decoder.sv
// Recovers base and step of an arithmetic sequence y(n) = base + n*step (mod 2^W),
// tracks lock, and counts prediction mismatches with saturating counters.
module seqsum_decoder #(
   parameter int unsigned W        = 32,
   parameter int unsigned CW       = 16,
   parameter int unsigned RELOCK_N = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          y_vld,
   input  logic [W-1:0]  y,
   output logic [W-1:0]  a_out,
   output logic [W-1:0]  b_out,
   output logic          locked,
   output logic          mismatch,
   output logic [CW-1:0] err_cnt,
   output logic [CW-1:0] smp_cnt
);

   // miss_run only needs to count up to RELOCK_N-1; the RELOCK_N-th miss relocks
   localparam int unsigned MW = (RELOCK_N > 1) ? $clog2(RELOCK_N) : 1;
   localparam logic [MW-1:0] LastMiss = MW'(RELOCK_N - 1);

   typedef enum logic [1:0] {StIdle, StFirst, StTrack} state_e;

   state_e          state_q;
   logic [W-1:0]    a_q, b_q, prev_q, pred_q;
   logic [MW-1:0]   miss_run_q;
   logic [CW-1:0]   err_q, smp_q;
   logic            locked_q, mismatch_q;

   logic [W-1:0]    diff;
   logic [CW-1:0]   err_inc, smp_inc;

   assign diff    = y - prev_q;
   assign err_inc = (err_q == '1) ? err_q : err_q + CW'(1);
   assign smp_inc = (smp_q == '1) ? smp_q : smp_q + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         a_q        <= '0;
         b_q        <= '0;
         prev_q     <= '0;
         pred_q     <= '0;
         miss_run_q <= '0;
         err_q      <= '0;
         smp_q      <= '0;
         locked_q   <= 1'b0;
         mismatch_q <= 1'b0;
      end else if (clr) begin
         state_q    <= StIdle;
         a_q        <= '0;
         b_q        <= '0;
         prev_q     <= '0;
         pred_q     <= '0;
         miss_run_q <= '0;
         err_q      <= '0;
         smp_q      <= '0;
         locked_q   <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         mismatch_q <= 1'b0;
         if (y_vld) begin
            unique case (state_q)
               StIdle: begin
                  a_q     <= y;
                  prev_q  <= y;
                  smp_q   <= CW'(1);
                  state_q <= StFirst;
               end
               StFirst: begin
                  b_q      <= diff;
                  pred_q   <= y + diff;
                  prev_q   <= y;
                  smp_q    <= smp_inc;
                  locked_q <= 1'b1;
                  state_q  <= StTrack;
               end
               StTrack: begin
                  if (y == pred_q) begin
                     pred_q     <= y + b_q;
                     miss_run_q <= '0;
                     smp_q      <= smp_inc;
                  end else begin
                     mismatch_q <= 1'b1;
                     err_q      <= err_inc;
                     // prediction keeps advancing so an isolated glitch does not break lock
                     pred_q     <= pred_q + b_q;
                     if (miss_run_q == LastMiss) begin
                        a_q        <= y;
                        prev_q     <= y;
                        smp_q      <= CW'(1);
                        miss_run_q <= '0;
                        locked_q   <= 1'b0;
                        state_q    <= StFirst;
                     end else begin
                        miss_run_q <= miss_run_q + MW'(1);
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign a_out    = a_q;
   assign b_out    = b_q;
   assign locked   = locked_q;
   assign mismatch = mismatch_q;
   assign err_cnt  = err_q;
   assign smp_cnt  = smp_q;

endmodule

// File: tb/tb_seqsum_decoder.sv
// Scoreboard bench for seqsum_decoder: directed scenarios plus random arithmetic sequences
// with corruptions, gaps, clears and resets, checked against a sample-level reference model.
module tb_seqsum_decoder;

   localparam int unsigned W    = 32;
   localparam int unsigned TCW  = 5;   // small so counter saturation is reachable
   localparam int unsigned RELOCK = 3;

   logic            clk = 1'b0;
   logic            rst_n, clr, y_vld;
   logic [W-1:0]    y;
   logic [W-1:0]    a_out, b_out;
   logic            locked, mismatch;
   logic [TCW-1:0]  err_cnt, smp_cnt;

   seqsum_decoder #(.W(W), .CW(TCW), .RELOCK_N(RELOCK)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .y_vld    (y_vld),
      .y        (y),
      .a_out    (a_out),
      .b_out    (b_out),
      .locked   (locked),
      .mismatch (mismatch),
      .err_cnt  (err_cnt),
      .smp_cnt  (smp_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   a, b;
      logic           lk, mm;
      logic [TCW-1:0] e, s;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   // Reference model: phase 0 = waiting for base, 1 = waiting for step, 2 = tracking
   int             m_phase;
   logic [W-1:0]   m_a, m_b, m_prev, m_pred;
   int             m_miss;
   int             m_err, m_smp;
   logic           m_lk, m_mm;
   localparam int  SatMax = (1 << TCW) - 1;

   function automatic int sat_inc(input int v);
      return (v >= SatMax) ? SatMax : v + 1;
   endfunction

   task automatic model_zero();
      m_phase = 0; m_a = '0; m_b = '0; m_prev = '0; m_pred = '0;
      m_miss = 0; m_err = 0; m_smp = 0; m_lk = 1'b0; m_mm = 1'b0;
   endtask

   task automatic model_apply(input logic r, input logic c, input logic v,
                              input logic [W-1:0] yy);
      if (!r || c) begin
         model_zero();
         return;
      end
      m_mm = 1'b0;
      if (!v) return;
      if (m_phase == 0) begin
         m_a = yy; m_prev = yy; m_smp = 1; m_phase = 1;
      end else if (m_phase == 1) begin
         m_b = yy - m_prev; m_pred = yy + m_b; m_prev = yy;
         m_smp = sat_inc(m_smp); m_phase = 2; m_lk = 1'b1;
      end else if (yy == m_pred) begin
         m_pred = yy + m_b; m_miss = 0; m_smp = sat_inc(m_smp);
      end else begin
         m_mm = 1'b1; m_err = sat_inc(m_err); m_miss++; m_pred = m_pred + m_b;
         if (m_miss == RELOCK) begin
            m_a = yy; m_prev = yy; m_smp = 1; m_miss = 0; m_lk = 1'b0; m_phase = 1;
         end
      end
   endtask

   task automatic step(input logic r, input logic c, input logic v, input logic [W-1:0] yy);
      exp_t e;
      @(negedge clk);
      rst_n = r; clr = c; y_vld = v; y = yy;
      model_apply(r, c, v, yy);
      e.a = m_a; e.b = m_b; e.lk = m_lk; e.mm = m_mm;
      e.e = TCW'(m_err); e.s = TCW'(m_smp);
      exp_q.push_back(e);
   endtask

   task automatic sample(input logic [W-1:0] yy);
      step(1'b1, 1'b0, 1'b1, yy);
   endtask

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
      n_chk++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h required %0h", name, $time, got, req);
      end
   endtask

   // Monitor: outputs are registered, so compare #1 after each rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("a_out",    a_out,          e.a);
            check("b_out",    b_out,          e.b);
            check("locked",   W'(locked),     W'(e.lk));
            check("mismatch", W'(mismatch),   W'(e.mm));
            check("err_cnt",  W'(err_cnt),    W'(e.e));
            check("smp_cnt",  W'(smp_cnt),    W'(e.s));
         end
      end
   end

   initial begin
      logic [W-1:0] base, stp, n, yy;
      logic         r, c, v;
      rst_n = 1'b0; clr = 1'b0; y_vld = 1'b0; y = '0;
      model_zero();

      // reset state, then junk while in reset must be ignored
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b1, 32'h1234);

      // 1: basic lock on step 10
      for (int i = 0; i < 5; i++) sample(W'(1 + 10 * i));
      // 2: single glitch keeps lock
      sample(99); sample(61); sample(71);
      // 3: three misses force relock, then relock on step 10
      sample(500); sample(600); sample(700); sample(710); sample(720);

      // 4: wrap-around
      step(1'b1, 1'b1, 1'b0, '0);
      sample(32'hFFFF_FFFE); sample(32'h0000_0001); sample(32'h0000_0004);

      // 5: gaps with junk y hold state
      step(1'b1, 1'b1, 1'b0, '0);
      sample(5);
      step(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
      step(1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
      sample(9); sample(13);

      // 6: clr with a valid sample while locked, then async reset mid-sequence
      step(1'b1, 1'b1, 1'b1, 777);
      sample(40); sample(50); sample(60);
      step(1'b0, 1'b0, 1'b1, 70);
      sample(300); sample(301);

      // saturation: long matching run, then sustained errors
      step(1'b1, 1'b1, 1'b0, '0);
      for (int i = 0; i < 40; i++) sample(W'(7 * i));
      for (int i = 0; i < 40; i++) sample($urandom);

      // randomized arithmetic sequences with corruption, gaps, clears and resets
      base = $urandom; stp = W'($urandom_range(20)); n = '0;
      for (int i = 0; i < 2000; i++) begin
         r = 1'b1; c = 1'b0;
         if ($urandom_range(149) == 0) r = 1'b0;
         else if ($urandom_range(149) == 0) c = 1'b1;
         if ($urandom_range(49) == 0) begin
            base = $urandom;
            stp  = ($urandom_range(3) == 0) ? W'($urandom) : W'($urandom_range(20));
            n    = '0;
         end
         v  = ($urandom_range(3) != 0);
         yy = base + n * stp;
         if ($urandom_range(11) == 0) yy = $urandom;
         step(r, c, v, v ? yy : W'($urandom));
         if (v) n++;
      end

      step(1'b1, 1'b0, 1'b0, '0);
      @(posedge clk);
      #2;
      check("scoreboard_drained", W'(exp_q.size()), '0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
